// File: rtl/fraud_result_fifo.sv
// Output stage for fraud decisions: tags each decision with a sequence number,
// buffers it in a FWFT FIFO drained over AXI4-Stream, and keeps status counters.
module fraud_result_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_data,
  input  logic             i_data_valid,
  input  logic             i_clear,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             o_fifo_full,
  output logic [CNT_W-1:0] o_occupancy,
  output logic             o_overflow,
  output logic [31:0]      o_txn_count,
  output logic [31:0]      o_fraud_count
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DW    = 32;
  localparam int unsigned SEQ_W = 16;
  localparam int unsigned PAD_W = DW - SEQ_W - 1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_occ;
  logic             r_full;
  logic             r_tvalid;
  logic [DW-1:0]    r_tdata;
  logic             r_overflow;
  logic [31:0]      r_txn;
  logic [31:0]      r_fraud;

  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [DW-1:0]    w_word;
  logic [CNT_W-1:0] w_occ_next;
  logic [DW-1:0]    w_head_next;
  logic [AW-1:0]    w_rd_ptr_inc;
  logic             w_unused_data;

  assign w_unused_data = ^i_data[31:1];

  assign w_pop        = r_tvalid & m_axis_tready;
  assign w_push       = i_data_valid & (~r_full | w_pop);
  assign w_drop       = i_data_valid & r_full & ~w_pop;
  assign w_word       = {r_txn[SEQ_W-1:0], PAD_W'(0), i_data[0]};
  assign w_rd_ptr_inc = AW'(r_rd_ptr + 1'b1);

  always_comb begin
    w_occ_next = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_next = CNT_W'(r_occ + 1'b1);
      2'b01:   w_occ_next = CNT_W'(r_occ - 1'b1);
      default: w_occ_next = r_occ;
    endcase
  end

  // Next head word, so tdata can be a register and still fall through in one cycle.
  always_comb begin
    w_head_next = r_tdata;
    if (w_occ_next == '0) begin
      w_head_next = '0;
    end else if (w_pop) begin
      if (r_occ == CNT_W'(1)) w_head_next = w_word;
      else                    w_head_next = r_mem[w_rd_ptr_inc];
    end else if (r_occ == '0) begin
      w_head_next = w_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_full   <= 1'b0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= AW'(r_wr_ptr + 1'b1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      r_occ    <= w_occ_next;
      r_full   <= (w_occ_next == CNT_W'(DEPTH));
      r_tvalid <= (w_occ_next != '0);
      r_tdata  <= w_head_next;
    end
  end

  // Status counters; clear wins over a coincident increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_txn      <= '0;
      r_fraud    <= '0;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_txn      <= '0;
      r_fraud    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_data_valid)             r_txn   <= r_txn + 32'd1;
      if (i_data_valid & i_data[0]) r_fraud <= r_fraud + 32'd1;
      if (w_drop)                   r_overflow <= 1'b1;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign o_fifo_full   = r_full;
  assign o_occupancy   = r_occ;
  assign o_overflow    = r_overflow;
  assign o_txn_count   = r_txn;
  assign o_fraud_count = r_fraud;

endmodule

// File: tb/tb_fraud_result_fifo.sv
// Directed bench for fraud_result_fifo: ordering, full/overflow, backpressure,
// clear, sequence wrap and asynchronous reset.
module tb_fraud_result_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic [31:0]      data;
  logic             data_valid;
  logic             clear;
  logic [31:0]      tdata;
  logic             tvalid;
  logic             tready;
  logic             fifo_full;
  logic [CNT_W-1:0] occupancy;
  logic             overflow;
  logic [31:0]      txn_count;
  logic [31:0]      fraud_count;

  int errors = 0;
  int checks = 0;

  fraud_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_data        (data),
    .i_data_valid  (data_valid),
    .i_clear       (clear),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .o_fifo_full   (fifo_full),
    .o_occupancy   (occupancy),
    .o_overflow    (overflow),
    .o_txn_count   (txn_count),
    .o_fraud_count (fraud_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    data       = '0;
    data_valid = 1'b0;
    clear      = 1'b0;
    tready     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [31:0] word(input int seq, input logic dec);
    return {16'(seq), 15'b0, dec};
  endfunction

  logic [31:0] prev;
  logic        stalled;
  int          sent;
  int          exp_seq;

  initial begin
    // Reset state
    do_reset();
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_txn", txn_count, 32'd0);

    // Three decisions streamed straight through
    tready = 1'b1;
    data_valid = 1'b1;
    data = 32'd1; step(); chk("t1_w0", tdata, 32'h0000_0001);
    data = 32'd0; step(); chk("t1_w1", tdata, 32'h0001_0000);
    data = 32'd1; step(); chk("t1_w2", tdata, 32'h0002_0001);
    chk("t1_tvalid", 32'(tvalid), 32'd1);
    data_valid = 1'b0; data = '0;
    step();
    chk("t1_empty", 32'(tvalid), 32'd0);
    chk("t1_txn", txn_count, 32'd3);
    chk("t1_fraud", fraud_count, 32'd2);

    // Fill, overflow, then drain
    do_reset();
    for (int i = 0; i < 20; i++) begin
      data_valid = 1'b1;
      data = 32'(i & 1);
      step();
      if (i == 15) begin
        chk("t2_full16", 32'(fifo_full), 32'd1);
        chk("t2_ovf16", 32'(overflow), 32'd0);
        chk("t2_occ16", 32'(occupancy), 32'd16);
      end
      if (i == 16) chk("t2_ovf17", 32'(overflow), 32'd1);
    end
    data_valid = 1'b0; data = '0;
    chk("t2_txn", txn_count, 32'd20);
    chk("t2_fraud", fraud_count, 32'd10);
    tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain", tdata, word(i, 1'(i & 1)));
      step();
    end
    chk("t2_empty", 32'(tvalid), 32'd0);
    chk("t2_ovf_sticky", 32'(overflow), 32'd1);

    // Push into a full FIFO while popping
    do_reset();
    for (int i = 0; i < 16; i++) begin
      data_valid = 1'b1; data = '0; step();
    end
    data = 32'd1; tready = 1'b1; step();
    data_valid = 1'b0; data = '0; tready = 1'b0;
    chk("t3_occ", 32'(occupancy), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_full", 32'(fifo_full), 32'd1);
    chk("t3_head", tdata, word(1, 1'b0));
    tready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      chk("t3_drain", tdata, word(i, 1'(i == 16)));
      step();
    end
    chk("t3_empty", 32'(tvalid), 32'd0);

    // Random backpressure: stalls hold tdata, sequence stays gap-free
    do_reset();
    sent = 0; exp_seq = 0; stalled = 1'b0; prev = '0;
    for (int c = 0; c < 600 && exp_seq < 40; c++) begin
      data_valid = (sent < 40) && ($urandom_range(1, 0) == 1) && (occupancy < 14);
      data = '0;
      tready = ($urandom_range(1, 0) == 1);
      if (stalled) chk("t4_stable", tdata, prev);
      if (tvalid && tready) begin
        chk("t4_seq", tdata, word(exp_seq, 1'b0));
        exp_seq++;
      end
      stalled = tvalid && !tready;
      prev = tdata;
      if (data_valid) sent++;
      step();
    end
    data_valid = 1'b0; tready = 1'b0;
    chk("t4_count", 32'(exp_seq), 32'd40);
    chk("t4_ovf", 32'(overflow), 32'd0);

    // Clear coincident with a valid fraud decision
    do_reset();
    for (int i = 0; i < 5; i++) begin
      data_valid = 1'b1; data = '0; step();
    end
    data = 32'd1; clear = 1'b1; step();
    clear = 1'b0;
    chk("t5_txn_clr", txn_count, 32'd0);
    chk("t5_fraud_clr", fraud_count, 32'd0);
    chk("t5_occ", 32'(occupancy), 32'd6);
    data = '0; step();
    data_valid = 1'b0;
    chk("t5_txn_after", txn_count, 32'd1);
    tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_drain", tdata, word(i, 1'b0));
      step();
    end
    chk("t5_tagged5", tdata, 32'h0005_0001); step();
    chk("t5_tagged0", tdata, 32'h0000_0000); step();
    chk("t5_empty", 32'(tvalid), 32'd0);

    // Sequence wrap, then asynchronous reset mid-stream
    do_reset();
    tready = 1'b1; data_valid = 1'b1; data = '0;
    for (int i = 0; i < 65537; i++) begin
      step();
      if (i == 65535) chk("t6_seq_ffff", tdata, 32'hFFFF_0000);
    end
    chk("t6_seq_wrap", tdata, 32'h0000_0000);
    chk("t6_txn", txn_count, 32'h0001_0001);
    data = 32'd1; step(); step();
    chk("t6_pre_rst", 32'(tvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", 32'(tvalid), 32'd0);
    chk("t6_rst_tdata", tdata, 32'd0);
    chk("t6_rst_txn", txn_count, 32'd0);
    chk("t6_rst_fraud", fraud_count, 32'd0);
    chk("t6_rst_occ", 32'(occupancy), 32'd0);
    data_valid = 1'b0; data = '0;
    step();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fraud_result_fifo.md
# fraud_result_fifo

Output stage directly downstream of the max-finder decision stage. Captures each registered fraud decision word on its valid pulse, tags it with a 16-bit transaction sequence number, and buffers it in a small FIFO drained through an AXI4-Stream master to the DMA/host path. Also maintains running transaction and fraud counters plus a sticky overflow flag for the control/status registers.

## Interface
- DEPTH, 16, FIFO depth in words; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), width of the occupancy output
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_data  in  32  decision word from the max-finder stage; only bit 0 is meaningful (1 = fraud)
- i_data_valid  in  1  single-cycle strobe; i_data sampled when high
- i_clear  in  1  synchronous clear of counters, sequence number and overflow flag
- m_axis_tdata  out  32  {seq[15:0], 15'b0, decision}
- m_axis_tvalid  out  1  FIFO non-empty
- m_axis_tready  in  1  downstream accept
- o_fifo_full  out  1  occupancy == DEPTH
- o_occupancy  out  CNT_W  words currently stored
- o_overflow  out  1  sticky: a decision was dropped
- o_txn_count  out  32  decisions received since reset/clear (wraps at 2^32)
- o_fraud_count  out  32  fraud decisions received since reset/clear (wraps at 2^32)

## Operation
- Reset (i_rst_n low, asynchronous): every output 0; FIFO empty; read/write pointers 0; sequence number 0.
- Push: on i_data_valid, word {seq, 15'b0, i_data[0]} is written if occupancy < DEPTH, or if occupancy == DEPTH and a pop occurs in the same cycle.
- Drop: on i_data_valid with FIFO full and no pop that cycle, the word is discarded and o_overflow is set (stays set until i_clear or reset).
- Pop: when m_axis_tvalid && m_axis_tready, head word is removed.
- Simultaneous push and pop: occupancy unchanged; both occur.
- seq = o_txn_count[15:0] before increment; increments on every i_data_valid, including dropped ones, so the host detects drops as sequence gaps. Wraps 0xFFFF -> 0x0000.
- o_txn_count += 1 on every i_data_valid; o_fraud_count += 1 when i_data_valid && i_data[0]; both counted regardless of drop.
- i_clear: counters, seq and o_overflow become 0 the next edge. Clear has priority over a coincident increment (result 0, sample not counted), but a coincident valid word is still pushed, tagged with the pre-clear seq. FIFO contents are not affected by i_clear.
- Pointers wrap modulo DEPTH; full/empty are derived from the occupancy counter, not from pointer equality alone.
- AXI-Stream rules: tdata is first-word-fall-through from the head and stays stable while tvalid && !tready; tvalid never deasserts without a handshake; no tlast/tkeep.

## Timing
- Push latency: word written at edge N (valid in cycle N-1) appears on m_axis_tdata with tvalid high in cycle N when the FIFO was empty.
- Pop: after handshake at edge N, the next word (or tvalid=0) is presented in cycle N.
- Counters, o_occupancy, o_fifo_full and o_overflow are registered and update at the edge that samples the event.
- Sustained throughput: one push and one pop per cycle.
- Reset mid-stream: FIFO is flushed; tvalid falls asynchronously with i_rst_n.

## Test plan
- Reset then three valids with i_data = 1, 0, 1, tready=1 -> tdata 0x00000001, 0x00010000, 0x00020001 in order; o_txn_count=3, o_fraud_count=2.
- tready=0, 20 valids with DEPTH=16 -> o_fifo_full=1 after 16th, o_overflow=1 after 17th, o_txn_count=20; releasing tready drains seq 0..15, then tvalid=0.
- FIFO full with tready=1 and valid in the same cycle -> push accepted, o_overflow stays 0, occupancy stays 16.
- Backpressure: tready toggled randomly -> tdata stable while stalled; output sequence numbers strictly consecutive with no loss.
- i_clear coincident with valid (i_data=1) after 5 transactions -> counters 0 next cycle, word with seq 5 still pushed; next valid tagged seq 0.
- 65537 valids with tready=1 -> seq wraps 0xFFFF to 0x0000; o_txn_count=65537; assert i_rst_n low mid-stream -> all outputs 0 immediately.
